klotski_board_ctrl: RTL and testbench

- Game-state engine of the Klotski design: consumes one-cycle debounced key pulses and maintains the 4-column x 5-row board, selected piece, move count and win flag.
- Feeds the VGA renderer (board and selection) and the seven-segment decoders (move count).
- Move legality is checked by a sequential 20-cell scan, then committed in one cycle.

---
 rtl/klotski_pkg.sv | 51 +++++
 rtl/klotski_cell_target.sv | 45 ++++
 rtl/klotski_board_ctrl.sv | 168 ++++++++++++++++
 tb/tb_klotski_board_ctrl.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/klotski_pkg.sv
// Shared constants, enums and board helpers for the Klotski game-state engine.
package klotski_pkg;

  localparam int BOARD_W = 4;
  localparam int BOARD_H = 5;
  localparam int NCELL   = 20;
  localparam int NPIECE  = 10;
  localparam int CELL_W  = 4;

  localparam logic [3:0] EMPTY   = 4'd0;
  localparam logic [3:0] GOAL_ID = 4'd1;

  typedef enum logic [1:0] {
    DIR_UP    = 2'd0,
    DIR_DOWN  = 2'd1,
    DIR_LEFT  = 2'd2,
    DIR_RIGHT = 2'd3
  } dir_e;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCAN  = 2'd1,
    APPLY = 2'd2,
    WIN   = 2'd3
  } state_e;

  // Cell 19 is the most significant nibble: rows listed bottom to top, right to left.
  localparam logic [79:0] INIT_BOARD = {
    4'd10, 4'd0, 4'd0, 4'd9,
    4'd6,  4'd8, 4'd7, 4'd4,
    4'd6,  4'd5, 4'd5, 4'd4,
    4'd3,  4'd1, 4'd1, 4'd2,
    4'd3,  4'd1, 4'd1, 4'd2
  };

  localparam int WIN_CELLS [4] = '{13, 14, 17, 18};

  function automatic logic [3:0] cell_of(input logic [79:0] b, input int c);
    return b[c*CELL_W +: CELL_W];
  endfunction

  function automatic logic win_check(input logic [79:0] b);
    logic w;
    w = 1'b1;
    for (int i = 0; i < 4; i++) begin
      w = w & (cell_of(b, WIN_CELLS[i]) == GOAL_ID);
    end
    return w;
  endfunction

endpackage

// File: rtl/klotski_cell_target.sv
// Neighbour cell of k in direction dir, flagging moves that would leave the board.
module klotski_cell_target
  import klotski_pkg::*;
(
  input  logic [4:0] k,
  input  dir_e       dir,
  output logic [4:0] t,
  output logic       off_board
);

  logic [2:0] row_s;
  logic [1:0] col_s;

  assign row_s = k[4:2];
  assign col_s = k[1:0];

  // Off-board targets keep t = k so downstream indexing always stays in range.
  always_comb begin
    t         = k;
    off_board = 1'b0;
    case (dir)
      DIR_UP: begin
        if (row_s == 3'd0) off_board = 1'b1;
        else               t = k - 5'd4;
      end
      DIR_DOWN: begin
        if (row_s == 3'(BOARD_H - 1)) off_board = 1'b1;
        else                          t = k + 5'd4;
      end
      DIR_LEFT: begin
        if (col_s == 2'd0) off_board = 1'b1;
        else               t = k - 5'd1;
      end
      DIR_RIGHT: begin
        if (col_s == 2'(BOARD_W - 1)) off_board = 1'b1;
        else                          t = k + 5'd1;
      end
      default: begin
        t         = k;
        off_board = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/klotski_board_ctrl.sv
// Klotski game-state engine: piece selection, 20-cycle legality scan, one-cycle
// move commit, saturating move counter and win detection.
module klotski_board_ctrl
  import klotski_pkg::*;
#(
  parameter int MOVE_MAX = 999,
  parameter int INIT_SEL = 1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_next,
  input  logic        i_move,
  input  logic [1:0]  i_dir,
  input  logic        i_restart,
  input  logic        i_load,
  input  logic [79:0] i_load_board,
  output logic [79:0] o_board,
  output logic [3:0]  o_sel,
  output logic [9:0]  o_moves,
  output logic        o_busy,
  output logic        o_move_ok,
  output logic        o_move_bad,
  output logic        o_win
);

  state_e      state_r;
  dir_e        dir_r;
  logic [79:0] board_r;
  logic [3:0]  sel_r;
  logic [9:0]  moves_r;
  logic [4:0]  k_r;
  logic        bad_r;
  logic        busy_r;
  logic        ok_pulse_r;
  logic        bad_pulse_r;
  logic        win_r;

  logic [4:0]  t_s   [NCELL];
  logic        off_s [NCELL];
  logic [3:0]  cell_k_s;
  logic [3:0]  cell_t_s;
  logic        scan_bad_s;
  logic [79:0] moved_s;
  logic [79:0] next_board_s;
  logic [3:0]  cell_v_s;

  // One target calculator per cell: the scan reads entry k_r, the commit uses all.
  for (genvar c = 0; c < NCELL; c++) begin : g_tgt
    klotski_cell_target u_tgt (
      .k         (5'(c)),
      .dir       (dir_r),
      .t         (t_s[c]),
      .off_board (off_s[c])
    );
  end

  // Legality of the cell currently under the scan pointer.
  always_comb begin
    cell_k_s = board_r[{k_r, 2'b00} +: 4];
    cell_t_s = board_r[{t_s[k_r], 2'b00} +: 4];
    if (cell_k_s == sel_r) begin
      scan_bad_s = off_s[k_r] || ((cell_t_s != EMPTY) && (cell_t_s != sel_r));
    end else begin
      scan_bad_s = 1'b0;
    end
  end

  // Shifted board: each destination takes sel if some sel cell targets it.
  always_comb begin
    moved_s  = board_r;
    cell_v_s = EMPTY;
    for (int d = 0; d < NCELL; d++) begin
      cell_v_s = (board_r[d*CELL_W +: CELL_W] == sel_r) ? EMPTY : board_r[d*CELL_W +: CELL_W];
      for (int c = 0; c < NCELL; c++) begin
        cell_v_s = ((board_r[c*CELL_W +: CELL_W] == sel_r) && !off_s[c] && (t_s[c] == 5'(d)))
                   ? sel_r : cell_v_s;
      end
      moved_s[d*CELL_W +: CELL_W] = cell_v_s;
    end
    next_board_s = bad_r ? board_r : moved_s;
  end

  // Game state machine; restart outranks load, which outranks normal operation.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_r     <= IDLE;
      dir_r       <= DIR_UP;
      board_r     <= INIT_BOARD;
      sel_r       <= 4'(INIT_SEL);
      moves_r     <= 10'd0;
      k_r         <= 5'd0;
      bad_r       <= 1'b0;
      busy_r      <= 1'b0;
      ok_pulse_r  <= 1'b0;
      bad_pulse_r <= 1'b0;
      win_r       <= 1'b0;
    end else begin
      ok_pulse_r  <= 1'b0;
      bad_pulse_r <= 1'b0;
      if (i_restart || i_load) begin
        board_r <= i_restart ? INIT_BOARD : i_load_board;
        sel_r   <= 4'(INIT_SEL);
        moves_r <= 10'd0;
        k_r     <= 5'd0;
        bad_r   <= 1'b0;
        busy_r  <= 1'b0;
        if (!i_restart && win_check(i_load_board)) begin
          state_r <= WIN;
          win_r   <= 1'b1;
        end else begin
          state_r <= IDLE;
          win_r   <= 1'b0;
        end
      end else begin
        case (state_r)
          IDLE: begin
            if (i_move) begin
              state_r <= SCAN;
              dir_r   <= dir_e'(i_dir);
              bad_r   <= 1'b0;
              k_r     <= 5'd0;
              busy_r  <= 1'b1;
            end else if (i_next) begin
              sel_r <= (sel_r == 4'(NPIECE)) ? 4'd1 : sel_r + 4'd1;
            end
          end
          SCAN: begin
            if (scan_bad_s) bad_r <= 1'b1;
            if (k_r == 5'(NCELL - 1)) state_r <= APPLY;
            else                      k_r <= k_r + 5'd1;
          end
          APPLY: begin
            busy_r  <= 1'b0;
            board_r <= next_board_s;
            if (bad_r) begin
              bad_pulse_r <= 1'b1;
            end else begin
              ok_pulse_r <= 1'b1;
              if (moves_r < 10'(MOVE_MAX)) moves_r <= moves_r + 10'd1;
            end
            if (win_check(next_board_s)) begin
              state_r <= WIN;
              win_r   <= 1'b1;
            end else begin
              state_r <= IDLE;
            end
          end
          WIN: begin
            win_r <= 1'b1;
          end
          default: begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign o_board    = board_r;
  assign o_sel      = sel_r;
  assign o_moves    = moves_r;
  assign o_busy     = busy_r;
  assign o_move_ok  = ok_pulse_r;
  assign o_move_bad = bad_pulse_r;
  assign o_win      = win_r;

endmodule

// File: tb/tb_klotski_board_ctrl.sv
// Self-checking bench: directed scenarios plus random selection/move sequences
// compared against a row/column reference model of the Klotski rules.
module tb_klotski_board_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_next;
  logic        i_move;
  logic [1:0]  i_dir;
  logic        i_restart;
  logic        i_load;
  logic [79:0] i_load_board;
  logic [79:0] o_board;
  logic [3:0]  o_sel;
  logic [9:0]  o_moves;
  logic        o_busy;
  logic        o_move_ok;
  logic        o_move_bad;
  logic        o_win;

  int n_checks = 0;
  int n_fail   = 0;

  int m_board [20];
  int m_sel;
  int m_moves;
  bit m_win;

  int init_rows [20] = '{2,1,1,3, 2,1,1,3, 4,5,5,6, 4,7,8,6, 9,0,0,10};

  always #5 i_clk = ~i_clk;

  klotski_board_ctrl #(.MOVE_MAX(999), .INIT_SEL(1)) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_next       (i_next),
    .i_move       (i_move),
    .i_dir        (i_dir),
    .i_restart    (i_restart),
    .i_load       (i_load),
    .i_load_board (i_load_board),
    .o_board      (o_board),
    .o_sel        (o_sel),
    .o_moves      (o_moves),
    .o_busy       (o_busy),
    .o_move_ok    (o_move_ok),
    .o_move_bad   (o_move_bad),
    .o_win        (o_win)
  );

  task automatic check_eq(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [79:0] pack_model();
    logic [79:0] b;
    for (int i = 0; i < 20; i++) b[i*4 +: 4] = 4'(m_board[i]);
    return b;
  endfunction

  function automatic bit model_win_now();
    return m_board[13] == 1 && m_board[14] == 1 && m_board[17] == 1 && m_board[18] == 1;
  endfunction

  task automatic model_init();
    m_board = init_rows;
    m_sel   = 1;
    m_moves = 0;
    m_win   = 1'b0;
  endtask

  // Move rule expressed on rows/columns of every cell holding the selected piece.
  task automatic model_move(input int d, output bit legal);
    int nb [20];
    int r, c, nr, nc;
    legal = 1'b1;
    for (int i = 0; i < 20; i++) nb[i] = (m_board[i] == m_sel) ? 0 : m_board[i];
    for (int i = 0; i < 20; i++) begin
      if (m_board[i] == m_sel) begin
        r = i / 4; c = i % 4; nr = r; nc = c;
        case (d)
          0:       nr = r - 1;
          1:       nr = r + 1;
          2:       nc = c - 1;
          default: nc = c + 1;
        endcase
        if (nr < 0 || nr > 4 || nc < 0 || nc > 3) begin
          legal = 1'b0;
        end else begin
          if (m_board[nr*4+nc] != 0 && m_board[nr*4+nc] != m_sel) legal = 1'b0;
          nb[nr*4+nc] = m_sel;
        end
      end
    end
    if (legal) begin
      m_board = nb;
      if (m_moves < 999) m_moves++;
    end
    m_win = model_win_now();
  endtask

  task automatic check_state(input string tag);
    check_eq({tag, "_board"}, o_board, pack_model());
    check_eq({tag, "_sel"},   o_sel,   80'(m_sel));
    check_eq({tag, "_moves"}, o_moves, 80'(m_moves));
    check_eq({tag, "_win"},   o_win,   80'(m_win));
  endtask

  task automatic press_next();
    @(negedge i_clk); i_next = 1'b1;
    @(negedge i_clk); i_next = 1'b0;
    if (!m_win) m_sel = (m_sel == 10) ? 1 : m_sel + 1;
  endtask

  task automatic do_restart(input string tag);
    @(negedge i_clk); i_restart = 1'b1;
    @(negedge i_clk); i_restart = 1'b0;
    model_init();
    check_state(tag);
    check_eq({tag, "_busy"}, o_busy, 80'd0);
    check_eq({tag, "_pulses"}, {o_move_ok, o_move_bad}, 80'd0);
  endtask

  task automatic do_load(input logic [79:0] b, input string tag);
    @(negedge i_clk); i_load = 1'b1; i_load_board = b;
    @(negedge i_clk); i_load = 1'b0;
    for (int i = 0; i < 20; i++) m_board[i] = int'(b[i*4 +: 4]);
    m_sel = 1; m_moves = 0; m_win = model_win_now();
    check_state(tag);
  endtask

  task automatic do_move(input int d, input bit with_next, input string tag);
    bit legal;
    int cyc;
    model_move(d, legal);
    @(negedge i_clk); i_move = 1'b1; i_dir = 2'(d); i_next = with_next;
    @(negedge i_clk); i_move = 1'b0; i_next = 1'b0;
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 40) begin
      cyc++;
      @(negedge i_clk);
    end
    check_eq({tag, "_busy_cycles"}, 80'(cyc), 80'd21);
    check_eq({tag, "_ok"},  o_move_ok,  80'(legal));
    check_eq({tag, "_bad"}, o_move_bad, 80'(!legal));
    check_state(tag);
    @(negedge i_clk);
    check_eq({tag, "_pulse_end"}, {o_move_ok, o_move_bad}, 80'd0);
  endtask

  task automatic move_ignored(input string tag);
    @(negedge i_clk); i_move = 1'b1; i_dir = 2'd0;
    @(negedge i_clk); i_move = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check_eq({tag, "_busy"}, o_busy, 80'd0);
      check_eq({tag, "_pulses"}, {o_move_ok, o_move_bad}, 80'd0);
      @(negedge i_clk);
    end
    check_state(tag);
  endtask

  initial begin
    logic [79:0] b;
    bit legal;
    i_rst_n = 1'b0; i_next = 1'b0; i_move = 1'b0; i_dir = 2'd0;
    i_restart = 1'b0; i_load = 1'b0; i_load_board = 80'd0;
    model_init();
    repeat (3) @(negedge i_clk);
    check_state("reset");
    check_eq("reset_busy", o_busy, 80'd0);
    i_rst_n = 1'b1;
    @(negedge i_clk);

    // Piece 9 steps right from the bottom-left corner.
    repeat (8) press_next();
    check_eq("sel_after_8", o_sel, 80'd9);
    do_move(3, 1'b0, "p9_right");
    check_eq("p9_cell17", o_board[17*4 +: 4], 80'd9);

    // Block piece 1 is obstructed by piece 5.
    do_restart("restart1");
    do_move(1, 1'b0, "p1_down_blocked");

    // Piece 2 off the left edge, then piece 7 down into the gap.
    press_next();
    do_move(2, 1'b0, "p2_left_off");
    repeat (5) press_next();
    check_eq("sel7", o_sel, 80'd7);
    do_move(1, 1'b0, "p7_down");

    // Async reset while the commit cycle is pending.
    @(negedge i_clk); i_move = 1'b1; i_dir = 2'd0;
    @(negedge i_clk); i_move = 1'b0;
    repeat (20) @(negedge i_clk);
    i_rst_n = 1'b0;
    #1;
    model_init();
    check_state("async_rst");
    check_eq("async_rst_busy", o_busy, 80'd0);
    check_eq("async_rst_pulses", {o_move_ok, o_move_bad}, 80'd0);
    @(negedge i_clk); i_rst_n = 1'b1;

    // Restart five cycles into a legal move's scan; nothing must commit later.
    repeat (8) press_next();
    @(negedge i_clk); i_move = 1'b1; i_dir = 2'd3;
    @(negedge i_clk); i_move = 1'b0;
    repeat (4) @(negedge i_clk);
    do_restart("restart_scan");
    repeat (20) @(negedge i_clk);
    check_state("restart_scan_late");
    check_eq("restart_scan_late_busy", o_busy, 80'd0);

    // Winning move, then everything but restart/load is ignored.
    b = 80'd0;
    foreach (init_rows[i]) b[i*4 +: 4] = 4'(init_rows[i]);
    for (int i = 1; i < 3; i++) begin b[i*4 +: 4] = 4'd0; b[(i+4)*4 +: 4] = 4'd0; end
    b[9*4 +: 4] = 4'd1;  b[10*4 +: 4] = 4'd1; b[13*4 +: 4] = 4'd1; b[14*4 +: 4] = 4'd1;
    b[17*4 +: 4] = 4'd0; b[18*4 +: 4] = 4'd0;
    do_load(b, "load_prewin");
    do_move(1, 1'b0, "win_move");
    check_eq("win_flag", o_win, 80'd1);
    move_ignored("win_ignore");
    press_next();
    check_eq("win_next_ignored", o_sel, 80'd1);

    // Saturation via legal no-op moves of absent piece 10.
    b = 80'd0;
    foreach (init_rows[i]) b[i*4 +: 4] = 4'(init_rows[i]);
    b[19*4 +: 4] = 4'd0;
    do_load(b, "load_nop");
    repeat (9) press_next();
    check_eq("sel10", o_sel, 80'd10);
    for (int i = 0; i < 999; i++) do_move(int'($urandom_range(0, 3)), 1'b0, "nop");
    check_eq("moves_999", o_moves, 80'd999);
    do_move(0, 1'b0, "nop_sat");
    check_eq("moves_sat", o_moves, 80'd999);

    // Random play against the reference model.
    do_restart("restart_rand");
    for (int n = 0; n < 150; n++) begin
      if (m_win) do_restart("rand_restart");
      if ($urandom_range(0, 2) == 0) begin
        press_next();
        check_eq("rand_sel", o_sel, 80'(m_sel));
      end else begin
        do_move(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), "rand_move");
      end
    end
    legal = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
